// File: rtl/mio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mio_bus_ctrl
//   Memory/IO bus controller between the CPU's MIO port and N_SLV slaves.
//   A request is decoded to one slave by an address field, then held for that
//   slave's programmable number of wait states. After that the controller waits
//   for the slave's ready, and finally it returns a one-cycle MIO_ready pulse with the
//   read data. A watchdog ends any access that stays in ACCESS for TIMEOUT cycles.
//   It then returns ERR_DATA, sets the sticky bus_err flag and records the failing address.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   CPU_MIO, mem_w      CPU request (held until MIO_ready) and write/read flag
//   Addr_out, Data_out  CPU address and write data
//   Data_in, MIO_ready  read data to CPU and one-cycle completion pulse
//   slv_sel, slv_we     one-hot slave select and write strobe (ACCESS only)
//   slv_addr, slv_wdata latched address / write data presented to slaves
//   slv_rdata, slv_rdy  packed per-slave read data and ready
//   slv_wait            packed per-slave wait-state counts
//   bus_err, err_addr   sticky timeout flag and address of last timed-out access
//   err_clr             clears bus_err / err_addr (a same-cycle timeout wins)
// -----------------------------------------------------------------------------
module mio_bus_ctrl #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter int                N_SLV    = 4,
   parameter int                SEL_LSB  = 28,
   parameter int                WAIT_W   = 4,
   parameter int                TIMEOUT  = 64,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     CPU_MIO,
   input  logic                     mem_w,
   input  logic [ADDR_W-1:0]        Addr_out,
   input  logic [DATA_W-1:0]        Data_out,
   output logic [DATA_W-1:0]        Data_in,
   output logic                     MIO_ready,
   output logic [N_SLV-1:0]         slv_sel,
   output logic                     slv_we,
   output logic [ADDR_W-1:0]        slv_addr,
   output logic [DATA_W-1:0]        slv_wdata,
   input  logic [N_SLV*DATA_W-1:0]  slv_rdata,
   input  logic [N_SLV-1:0]         slv_rdy,
   input  logic [N_SLV*WAIT_W-1:0]  slv_wait,
   output logic                     bus_err,
   input  logic                     err_clr,
   output logic [ADDR_W-1:0]        err_addr
);

   localparam int SEL_W = $clog2(N_SLV);
   // One spare bit so TIMEOUT-1 always fits, whatever TIMEOUT is.
   localparam int TC_W  = $clog2(TIMEOUT) + 1;
   localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [SEL_W-1:0]  idx_q;
   logic [SEL_W-1:0]  req_idx;
   logic [WAIT_W-1:0] wcnt;
   logic [TC_W-1:0]   tcnt;
   logic              mem_w_q;
   logic              hit_rdy;
   logic              hit_timeout;

   assign req_idx   = Addr_out[SEL_LSB +: SEL_W];
   assign MIO_ready = (state == DONE);

   // NOTE: every signal written in an always_comb gets a default on entry;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_nxt   = state;
      hit_rdy     = 1'b0;
      hit_timeout = 1'b0;
      unique case (state)
         IDLE: begin
            if (CPU_MIO) state_nxt = ACCESS;
         end
         ACCESS: begin
            // Wait states mask slv_rdy entirely; ready beats a same-edge timeout.
            if (wcnt == '0) begin
               if (slv_rdy[idx_q]) begin
                  hit_rdy   = 1'b1;
                  state_nxt = DONE;
               end else if (tcnt == TC_LAST) begin
                  hit_timeout = 1'b1;
                  state_nxt   = DONE;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Select and strobe are decoded from state, so an asynchronous reset
   // drops them in the same cycle.
   always_comb begin
      slv_sel = '0;
      if (state == ACCESS) slv_sel[idx_q] = 1'b1;
      slv_we = (state == ACCESS) && mem_w_q;
   end

   // NOTE: sequential state is assigned with non-blocking (<=) so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_w_q   <= 1'b0;
         slv_addr  <= '0;
         slv_wdata <= '0;
         idx_q     <= '0;
         wcnt      <= '0;
         tcnt      <= '0;
         Data_in   <= '0;
      end else begin
         if (state == IDLE && CPU_MIO) begin
            mem_w_q   <= mem_w;
            slv_addr  <= Addr_out;
            slv_wdata <= Data_out;
            idx_q     <= req_idx;
            wcnt      <= slv_wait[req_idx*WAIT_W +: WAIT_W];
            tcnt      <= '0;
         end
         if (state == ACCESS) begin
            tcnt <= tcnt + TC_W'(1);
            if (wcnt != '0) wcnt <= wcnt - WAIT_W'(1);
         end
         // Writes return zero so the CPU never sees stale read data.
         if (hit_rdy)
            Data_in <= mem_w_q ? '0 : slv_rdata[idx_q*DATA_W +: DATA_W];
         else if (hit_timeout)
            Data_in <= ERR_DATA;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_err  <= 1'b0;
         err_addr <= '0;
      end else if (hit_timeout) begin
         bus_err  <= 1'b1;
         err_addr <= slv_addr;
      end else if (err_clr) begin
         bus_err  <= 1'b0;
         err_addr <= '0;
      end
   end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mio_bus_ctrl
//   Directed bench for mio_bus_ctrl with default parameters. Inputs are driven
//   and outputs sampled on the falling clock edge. Latency is counted in falling
//   edges after the request is raised: wait=0 completes with lat=2.
// -----------------------------------------------------------------------------
module tb_mio_bus_ctrl;

   logic          clk = 1'b0;
   logic          reset;
   logic          CPU_MIO;
   logic          mem_w;
   logic [31:0]   Addr_out;
   logic [31:0]   Data_out;
   logic [31:0]   Data_in;
   logic          MIO_ready;
   logic [3:0]    slv_sel;
   logic          slv_we;
   logic [31:0]   slv_addr;
   logic [31:0]   slv_wdata;
   logic [127:0]  slv_rdata;
   logic [3:0]    slv_rdy;
   logic [15:0]   slv_wait;
   logic          bus_err;
   logic          err_clr;
   logic [31:0]   err_addr;

   int total = 0;
   int bad   = 0;

   int         lat;
   int         sel_cnt;
   int         we_cnt;
   logic [3:0] last_sel;
   int         t1;
   int         t2;

   localparam int BUDGET = 200;

   always #5 clk = ~clk;

   mio_bus_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .CPU_MIO   (CPU_MIO),
      .mem_w     (mem_w),
      .Addr_out  (Addr_out),
      .Data_out  (Data_out),
      .Data_in   (Data_in),
      .MIO_ready (MIO_ready),
      .slv_sel   (slv_sel),
      .slv_we    (slv_we),
      .slv_addr  (slv_addr),
      .slv_wdata (slv_wdata),
      .slv_rdata (slv_rdata),
      .slv_rdy   (slv_rdy),
      .slv_wait  (slv_wait),
      .bus_err   (bus_err),
      .err_clr   (err_clr),
      .err_addr  (err_addr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One CPU access. After the first ACCESS cycle the CPU-side inputs are
   // scrambled so the bench can confirm that the latched copies are used.
   // The bits in rise_mask are ORed into slv_rdy before the edge that follows
   // falling edge number rise_at.
   task automatic do_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input int rise_at, input logic [3:0] rise_mask);
      Addr_out = a; mem_w = w; Data_out = d; CPU_MIO = 1'b1;
      lat = 0; sel_cnt = 0; we_cnt = 0; last_sel = '0;
      while (lat < BUDGET) begin
         @(negedge clk);
         lat++;
         if (slv_sel != '0) begin sel_cnt++; last_sel = slv_sel; end
         if (slv_we) we_cnt++;
         if (MIO_ready) break;
         if (lat == 1) begin
            Addr_out = ~a; Data_out = ~d; mem_w = ~w; slv_wait = 16'hFFFF;
         end
         if (lat == rise_at) slv_rdy = slv_rdy | rise_mask;
      end
      CPU_MIO = 1'b0;
      @(negedge clk);
      chk("ready_one_cycle", {31'd0, MIO_ready}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; CPU_MIO = 1'b0; mem_w = 1'b0; Addr_out = '0; Data_out = '0;
      err_clr = 1'b0; slv_rdy = 4'b1111; slv_wait = '0;
      slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0A0A_5555};
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_ready",   {31'd0, MIO_ready}, 32'd0);
      chk("rst_sel",     {28'd0, slv_sel},   32'd0);
      chk("rst_we",      {31'd0, slv_we},    32'd0);
      chk("rst_addr",    slv_addr,           32'd0);
      chk("rst_data_in", Data_in,            32'd0);
      chk("rst_bus_err", {31'd0, bus_err},   32'd0);
      chk("rst_err_addr", err_addr,          32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Read slave 1, no wait states
      slv_wait = 16'h0000; slv_rdy = 4'b1111;
      do_access(32'h1000_0004, 1'b0, 32'h0, 0, 4'b0);
      chk("rd1_lat",     lat,               32'd2);
      chk("rd1_sel_cnt", sel_cnt,           32'd1);
      chk("rd1_sel",     {28'd0, last_sel}, 32'h2);
      chk("rd1_we_cnt",  we_cnt,            32'd0);
      chk("rd1_data",    Data_in,           32'h1234_5678);
      chk("rd1_addr",    slv_addr,          32'h1000_0004);

      // Write slave 3, three wait states
      slv_wait = {4'd3, 4'd0, 4'd0, 4'd0}; slv_rdy = 4'b1111;
      do_access(32'h3000_0010, 1'b1, 32'hCAFE_0001, 0, 4'b0);
      chk("wr3_lat",     lat,               32'd5);
      chk("wr3_sel_cnt", sel_cnt,           32'd4);
      chk("wr3_sel",     {28'd0, last_sel}, 32'h8);
      chk("wr3_we_cnt",  we_cnt,            32'd4);
      chk("wr3_wdata",   slv_wdata,         32'hCAFE_0001);
      chk("wr3_data_in", Data_in,           32'h0);
      chk("wr3_bus_err", {31'd0, bus_err},  32'd0);

      // Read slave 2 that never becomes ready: timeout
      slv_wait = '0; slv_rdy = 4'b1011;
      do_access(32'h2000_0008, 1'b0, 32'h0, 0, 4'b0);
      chk("to_lat",      lat,              32'd65);
      chk("to_sel_cnt",  sel_cnt,          32'd64);
      chk("to_data",     Data_in,          32'hDEAD_BEEF);
      chk("to_bus_err",  {31'd0, bus_err}, 32'd1);
      chk("to_err_addr", err_addr,         32'h2000_0008);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("clr_bus_err",  {31'd0, bus_err}, 32'd0);
      chk("clr_err_addr", err_addr,         32'd0);

      // Slave 0 becomes ready on the final timeout edge: ready wins
      slv_wait = '0; slv_rdy = 4'b1110;
      do_access(32'h0000_0020, 1'b0, 32'h0, 64, 4'b0001);
      chk("edge_lat",     lat,              32'd65);
      chk("edge_data",    Data_in,          32'h0A0A_5555);
      chk("edge_bus_err", {31'd0, bus_err}, 32'd0);

      // Reset two cycles into a wait=5 access to slave 1
      slv_wait = {4'd0, 4'd0, 4'd5, 4'd0}; slv_rdy = 4'b1111;
      Addr_out = 32'h1000_0040; mem_w = 1'b1; Data_out = 32'h5555_AAAA; CPU_MIO = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_sel", {28'd0, slv_sel}, 32'h2);
      chk("mid_we",  {31'd0, slv_we},  32'd1);
      #2 reset = 1'b1; CPU_MIO = 1'b0;
      #1;
      chk("arst_sel",   {28'd0, slv_sel},   32'd0);
      chk("arst_we",    {31'd0, slv_we},    32'd0);
      chk("arst_ready", {31'd0, MIO_ready}, 32'd0);
      chk("arst_addr",  slv_addr,           32'd0);
      chk("arst_data",  Data_in,            32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, MIO_ready}, 32'd0);
      slv_wait = '0;
      do_access(32'h1000_0000, 1'b0, 32'h0, 0, 4'b0);
      chk("post_rst_lat",  lat,     32'd2);
      chk("post_rst_data", Data_in, 32'h1234_5678);

      // Back-to-back reads with CPU_MIO held high
      slv_wait = '0; slv_rdy = 4'b1111;
      Addr_out = 32'h0000_0000; mem_w = 1'b0; CPU_MIO = 1'b1;
      lat = 0; t1 = 0; t2 = 0;
      while (lat < BUDGET && t2 == 0) begin
         @(negedge clk);
         lat++;
         if (MIO_ready) begin
            if (t1 == 0) begin
               t1 = lat;
               chk("b2b_data0", Data_in, 32'h0A0A_5555);
               Addr_out = 32'h1000_0000;
            end else begin
               t2 = lat;
               chk("b2b_data1", Data_in, 32'h1234_5678);
            end
         end
      end
      CPU_MIO = 1'b0;
      chk("b2b_first", t1,      32'd2);
      chk("b2b_gap",   t2 - t1, 32'd3);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
